// File: rtl/fpu_pkg.sv
// Shared constants and the completion-entry layout for the FP dispatch block.
package fpu_pkg;

  localparam int FPU_NUM_UNITS_DEF = 8;
  localparam int FPU_DEPTH_DEF     = 4;
  localparam int FPU_TAG_W_DEF     = 5;

  // Entry fields are sized for the largest supported configuration.
  localparam int FPU_UNIT_W_MAX = 5;
  localparam int FPU_TAG_W_MAX  = 8;

  localparam int FPU_ADD   = 0;
  localparam int FPU_SUB   = 1;
  localparam int FPU_MUL   = 2;
  localparam int FPU_DIV   = 3;
  localparam int FPU_SQRT  = 4;
  localparam int FPU_ITOF  = 5;
  localparam int FPU_FTOI  = 6;
  localparam int FPU_SPARE = 7;

  typedef struct packed {
    logic [FPU_UNIT_W_MAX-1:0] unit;
    logic [FPU_TAG_W_MAX-1:0]  tag;
    logic                      done;
    logic [31:0]               data;
  } fpu_entry_t;

endpackage

// File: rtl/fpu_cbuf.sv
// Circular completion storage with per-unit oldest-pending-entry search.
module fpu_cbuf
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = FPU_NUM_UNITS_DEF,
  parameter int DEPTH     = FPU_DEPTH_DEF,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [PW-1:0]               wr_ptr,
  input  fpu_entry_t                  wr_entry,
  input  logic [PW-1:0]               head_ptr,
  input  logic [CW-1:0]               count,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS-1:0][31:0]  unit_y,
  output fpu_entry_t                  head_entry,
  output logic [NUM_UNITS-1:0]        miss
);

  fpu_entry_t mem_q [DEPTH];
  fpu_entry_t mem_d [DEPTH];
  logic [NUM_UNITS*DEPTH-1:0] hit;

  // Each unit completes in order, so its result belongs to the oldest
  // occupied, not-yet-done entry tagged with that unit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic [DEPTH-1:0] hit_c;
      logic             found_c;
      logic [PW-1:0]    idx_c;

      always_comb begin
        hit_c   = '0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = 0; i < DEPTH; i++) begin
          idx_c = head_ptr + PW'(i);
          if (!found_c && unit_valid[gi] && (CW'(i) < count) &&
              !mem_q[idx_c].done && (mem_q[idx_c].unit == FPU_UNIT_W_MAX'(gi))) begin
            hit_c[idx_c] = 1'b1;
            found_c      = 1'b1;
          end
        end
      end

      assign hit[gi*DEPTH +: DEPTH] = hit_c;
      assign miss[gi]               = unit_valid[gi] && !found_c;
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (hit[u*DEPTH + j]) begin
          mem_d[j].done = 1'b1;
          mem_d[j].data = unit_y[u];
        end
      end
    end
    // The tail slot is free, so a new issue never collides with a completion.
    if (wr_en) begin
      mem_d[wr_ptr] = wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
    end
  end

  assign head_entry = mem_q[head_ptr];

endmodule

// File: rtl/fpu_dispatch.sv
// In-order issue/retire dispatcher for a bank of pipelined FP units.
// Define FPU_DISPATCH_BYPASS_EN for zero-latency retire of a completing head op.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = FPU_NUM_UNITS_DEF,
  parameter int DEPTH     = FPU_DEPTH_DEF,
  parameter int TAG_W     = FPU_TAG_W_DEF,
  localparam int UW       = $clog2(NUM_UNITS),
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [UW-1:0]               req_unit,
  input  logic [TAG_W-1:0]            req_tag,
  output logic [NUM_UNITS-1:0]        unit_en,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS-1:0][31:0]  unit_y,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [31:0]                 res_data,
  output logic [TAG_W-1:0]            res_tag,
  output logic                        idle,
  output logic                        err
);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  fpu_entry_t             head_e, wr_e;
  logic [NUM_UNITS-1:0]   miss;
  logic                   accept, retire, bad_unit, head_live;

  assign req_ready = (count_q != CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign bad_unit  = ({1'b0, req_unit} >= (UW+1)'(NUM_UNITS));
  assign head_live = (count_q != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_en
      assign unit_en[gi] = accept && !bad_unit && (req_unit == UW'(gi));
    end
  endgenerate

  // An op to a nonexistent unit is stored already done so it retires as zero.
  always_comb begin
    wr_e      = '0;
    wr_e.unit = FPU_UNIT_W_MAX'(req_unit);
    wr_e.tag  = FPU_TAG_W_MAX'(req_tag);
    wr_e.done = bad_unit;
  end

  fpu_cbuf #(
    .NUM_UNITS (NUM_UNITS),
    .DEPTH     (DEPTH)
  ) u_cbuf (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (accept),
    .wr_ptr     (tail_q),
    .wr_entry   (wr_e),
    .head_ptr   (head_q),
    .count      (count_q),
    .unit_valid (unit_valid),
    .unit_y     (unit_y),
    .head_entry (head_e),
    .miss       (miss)
  );

`ifdef FPU_DISPATCH_BYPASS_EN
  logic head_in_range, bypass_hit;
  assign head_in_range = (head_e.unit < FPU_UNIT_W_MAX'(NUM_UNITS));
  assign bypass_hit    = head_live && !head_e.done && head_in_range &&
                         unit_valid[head_e.unit[UW-1:0]];
  assign res_valid     = head_live && (head_e.done || bypass_hit);
  assign res_data      = bypass_hit ? unit_y[head_e.unit[UW-1:0]] : head_e.data;
`else
  assign res_valid = head_live && head_e.done;
  assign res_data  = head_e.data;
`endif

  assign res_tag = head_e.tag[TAG_W-1:0];
  assign retire  = res_valid && res_ready;

  always_comb begin
    head_d  = retire ? head_q + PW'(1) : head_q;
    tail_d  = accept ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(accept) - CW'(retire);
    err_d   = err_q || (|miss) || (accept && bad_unit);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign idle = (count_q == '0);
  assign err  = err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch: issue, ordering, backpressure, errors, reset.
module tb_fpu_dispatch;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_unit;
  logic [4:0]       req_tag;
  logic [7:0]       unit_en;
  logic [7:0]       unit_valid;
  logic [7:0][31:0] unit_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [4:0]       res_tag;
  logic             idle;
  logic             err;

  int tests = 0;
  int fails = 0;

  fpu_dispatch dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_unit   (req_unit),
    .req_tag    (req_tag),
    .unit_en    (unit_en),
    .unit_valid (unit_valid),
    .unit_y     (unit_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .idle       (idle),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input int t);
    req_valid = 1'b1;
    req_unit  = 3'(u);
    req_tag   = 5'(t);
    $display("[TB] issue unit %0d tag %0d", u, t);
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse(input int u, input logic [31:0] d);
    unit_valid[u] = 1'b1;
    unit_y[u]     = d;
    $display("[TB] complete unit %0d data %08h", u, d);
    step();
    unit_valid = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_unit = '0; req_tag = '0;
    unit_valid = '0; unit_y = '0; res_ready = 1'b0;
    step(); step();
    #3;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (unit_en !== 8'h00) begin fails++; $display("FAIL reset_unit_en got %h want 00", unit_en); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    tests++; if (res_data !== 32'h0) begin fails++; $display("FAIL reset_res_data got %h want 0", res_data); end
    tests++; if (res_tag !== 5'd0) begin fails++; $display("FAIL reset_res_tag got %0d want 0", res_tag); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_unit = 3'd0; req_tag = 5'd3;
    #4;
    tests++; if (unit_en !== 8'h01) begin fails++; $display("FAIL single_unit_en got %h want 01", unit_en); end
    $display("[TB] issue unit 0 tag 3");
    step();
    req_valid = 1'b0;
    #4;
    tests++; if (unit_en !== 8'h00) begin fails++; $display("FAIL single_en_drop got %h want 00", unit_en); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", idle); end
    step(); step(); step();
    unit_valid[0] = 1'b1; unit_y[0] = 32'h3F80_0000;
    #4;
`ifdef FPU_DISPATCH_BYPASS_EN
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_bypass got %b want 1", res_valid); end
`else
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_early got %b want 0", res_valid); end
`endif
    step();
    unit_valid = '0; unit_y[0] = 32'hDEAD_BEEF;
    #4;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", res_valid); end
    tests++; if (res_data !== 32'h3F80_0000) begin fails++; $display("FAIL single_data got %h want 3f800000", res_data); end
    tests++; if (res_tag !== 5'd3) begin fails++; $display("FAIL single_tag got %0d want 3", res_tag); end
    step();
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h3F80_0000 || res_tag !== 5'd3) begin
      fails++; $display("FAIL single_hold got v=%b d=%h t=%0d want 1 3f800000 3", res_valid, res_data, res_tag); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    $display("[TB] retire tag 3");
    tests++; if (res_valid !== 1'b0 || idle !== 1'b1) begin
      fails++; $display("FAIL single_retire got v=%b idle=%b want 0 1", res_valid, idle); end
  endtask

  task automatic test_order();
    issue(3, 1);
    issue(0, 2);
    pulse(0, 32'h4000_0000);
    #4;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL order_blocked got %b want 0", res_valid); end
    pulse(3, 32'h3F00_0000);
    #4;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd1 || res_data !== 32'h3F00_0000) begin
      fails++; $display("FAIL order_first got v=%b t=%0d d=%h want 1 1 3f000000", res_valid, res_tag, res_data); end
    res_ready = 1'b1;
    step();
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd2 || res_data !== 32'h4000_0000) begin
      fails++; $display("FAIL order_second got v=%b t=%0d d=%h want 1 2 40000000", res_valid, res_tag, res_data); end
    step();
    res_ready = 1'b0;
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL order_idle got %b want 1", idle); end
  endtask

  task automatic test_full();
    issue(1, 4); issue(1, 5); issue(2, 6); issue(3, 7);
    #3;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", req_ready); end
    req_valid = 1'b1; req_unit = 3'd0; req_tag = 5'd9;
    #1;
    tests++; if (unit_en !== 8'h00) begin fails++; $display("FAIL full_no_accept got %h want 00", unit_en); end
    pulse(1, 32'h0000_0011);
    res_ready = 1'b1;
    #4;
    tests++; if (req_ready !== 1'b0 || unit_en !== 8'h00) begin
      fails++; $display("FAIL full_retire_ready got rdy=%b en=%h want 0 00", req_ready, unit_en); end
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd4 || res_data !== 32'h11) begin
      fails++; $display("FAIL full_head got v=%b t=%0d d=%h want 1 4 11", res_valid, res_tag, res_data); end
    step();
    req_valid = 1'b0; res_ready = 1'b0;
    $display("[TB] retire tag 4");
    #4;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL full_reopen got %b want 1", req_ready); end
    unit_valid = 8'b0000_1110;
    unit_y[1] = 32'h22; unit_y[2] = 32'h33; unit_y[3] = 32'h44;
    $display("[TB] complete units 1,2,3 together");
    step();
    unit_valid = '0;
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd5 || res_data !== 32'h22) begin
      fails++; $display("FAIL multi_tag5 got v=%b t=%0d d=%h want 1 5 22", res_valid, res_tag, res_data); end
    res_ready = 1'b1;
    step();
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd6 || res_data !== 32'h33) begin
      fails++; $display("FAIL multi_tag6 got v=%b t=%0d d=%h want 1 6 33", res_valid, res_tag, res_data); end
    step();
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd7 || res_data !== 32'h44) begin
      fails++; $display("FAIL multi_tag7 got v=%b t=%0d d=%h want 1 7 44", res_valid, res_tag, res_data); end
    step();
    res_ready = 1'b0;
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL full_drain got %b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    issue(2, 8); issue(2, 9);
    pulse(2, 32'hAAAA_0001);
    pulse(2, 32'hBBBB_0002);
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd8 || res_data !== 32'hAAAA_0001) begin
      fails++; $display("FAIL mul_first got v=%b t=%0d d=%h want 1 8 aaaa0001", res_valid, res_tag, res_data); end
    res_ready = 1'b1;
    issue(4, 10);
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd9 || res_data !== 32'hBBBB_0002) begin
      fails++; $display("FAIL mul_second got v=%b t=%0d d=%h want 1 9 bbbb0002", res_valid, res_tag, res_data); end
    step();
    #3;
    tests++; if (res_valid !== 1'b0 || idle !== 1'b0) begin
      fails++; $display("FAIL b2b_pending got v=%b idle=%b want 0 0", res_valid, idle); end
    pulse(4, 32'hCCCC_0003);
    #3;
    tests++; if (res_valid !== 1'b1 || res_tag !== 5'd10 || res_data !== 32'hCCCC_0003) begin
      fails++; $display("FAIL b2b_tag10 got v=%b t=%0d d=%h want 1 10 cccc0003", res_valid, res_tag, res_data); end
    step();
    res_ready = 1'b0;
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b want 1", idle); end
  endtask

  task automatic test_err();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clean got %b want 0", err); end
    pulse(5, 32'h1234_5678);
    #3;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL err_ignored got idle=%b want 1", idle); end
    step(); step(); step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    issue(0, 11); issue(1, 12); issue(2, 13);
    pulse(0, 32'h5555_5555);
    #3;
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got %b want 1", res_valid); end
    rstn = 1'b0;
    $display("[TB] async reset with 3 ops pending");
    #1;
    tests++; if (idle !== 1'b1 || res_valid !== 1'b0) begin
      fails++; $display("FAIL mid_async got idle=%b v=%b want 1 0", idle, res_valid); end
    tests++; if (err !== 1'b0 || req_ready !== 1'b1 || res_data !== 32'h0) begin
      fails++; $display("FAIL mid_clear got err=%b rdy=%b d=%h want 0 1 0", err, req_ready, res_data); end
    step(); step();
    rstn = 1'b1;
    step();
    pulse(1, 32'h6666_6666);
    #3;
    tests++; if (err !== 1'b1 || idle !== 1'b1) begin
      fails++; $display("FAIL mid_spurious got err=%b idle=%b want 1 1", err, idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
